seg_scan_driver: RTL

Time-multiplexed display driver for the eight-digit seven-segment readout. Takes the eight parallel 7-bit segment patterns produced by the hex-to-segment encoder and drives a single shared segment bus plus a one-hot digit select. Each digit is shown for one scan slot. Patterns are snapshotted once per frame so a digit never changes mid-frame.

---
 rtl/seg_scan_driver_if.sv | 38 +++
 rtl/seg_scan_driver.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Bus bundle for seg_scan_driver.
//   en         : scan enable (master -> slave)
//   s1..s8     : 7-bit segment patterns, bit6=a .. bit0=g, s1 is the rightmost digit
//   bright     : 4-bit brightness, only with SEG_SCAN_BRIGHT_EN defined
//   seg_out    : shared segment bus (slave -> master)
//   dig_sel    : one-hot digit enable, bit0 drives the s1 digit
//   frame_done : one-cycle end-of-frame pulse
// Optional feature macro: SEG_SCAN_BRIGHT_EN.
interface seg_scan_driver_if;
    logic       en;
    logic [6:0] s1, s2, s3, s4, s5, s6, s7, s8;
`ifdef SEG_SCAN_BRIGHT_EN
    logic [3:0] bright;
`endif
    logic [6:0] seg_out;
    logic [7:0] dig_sel;
    logic       frame_done;

`ifdef SEG_SCAN_BRIGHT_EN
    modport master (
        output en, s1, s2, s3, s4, s5, s6, s7, s8, bright,
        input  seg_out, dig_sel, frame_done
    );
    modport slave (
        input  en, s1, s2, s3, s4, s5, s6, s7, s8, bright,
        output seg_out, dig_sel, frame_done
    );
`else
    modport master (
        output en, s1, s2, s3, s4, s5, s6, s7, s8,
        input  seg_out, dig_sel, frame_done
    );
    modport slave (
        input  en, s1, s2, s3, s4, s5, s6, s7, s8,
        output seg_out, dig_sel, frame_done
    );
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed eight-digit seven-segment scan driver.
// Each digit slot is SCAN_DIV cycles: BLANK_CYC dark cycles, then the digit is shown.
// Patterns are snapshotted at frame start so a digit never changes mid-frame.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_driver_if.slave (en, s1..s8, [bright], seg_out, dig_sel, frame_done)
// Optional feature macro: SEG_SCAN_BRIGHT_EN adds a 4-bit PWM brightness control
// on the segment bus during SHOW (dig_sel is not gated).
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBlank = 2'd1;
    localparam logic [1:0] StShow  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       shadow_q [8];
    logic [6:0]       shadow_d [8];
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       dig_q, dig_d;
    logic             fd_q, fd_d;
    logic [6:0]       pat_in [8];
`ifdef SEG_SCAN_BRIGHT_EN
    logic [3:0]       p_q, p_d;
`endif

    always_comb begin
        pat_in[0] = bus.s1;
        pat_in[1] = bus.s2;
        pat_in[2] = bus.s3;
        pat_in[3] = bus.s4;
        pat_in[4] = bus.s5;
        pat_in[5] = bus.s6;
        pat_in[6] = bus.s7;
        pat_in[7] = bus.s8;
    end

    // Outputs are computed for the next cycle so they register with the state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        seg_d    = '0;
        dig_d    = '0;
        fd_d     = 1'b0;
`ifdef SEG_SCAN_BRIGHT_EN
        p_d      = p_q;
`endif
        if (!bus.en) begin
            // Disable wins over every boundary: no capture, no frame_done.
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d  = StBlank;
                    cnt_d    = '0;
                    idx_d    = '0;
                    shadow_d = pat_in;
                end
                StBlank: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = StShow;
                        dig_d   = 8'h01 << idx_q;
                        // First SHOW cycle has p=0, which is always within bright.
                        seg_d   = shadow_q[idx_q];
`ifdef SEG_SCAN_BRIGHT_EN
                        p_d     = '0;
`endif
                    end
                end
                StShow: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            shadow_d = pat_in;
                            fd_d     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        dig_d = 8'h01 << idx_q;
`ifdef SEG_SCAN_BRIGHT_EN
                        p_d   = p_q + 4'd1;
                        seg_d = (p_d <= bus.bright) ? shadow_q[idx_q] : 7'd0;
`else
                        seg_d = shadow_q[idx_q];
`endif
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            dig_q   <= '0;
            fd_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
            end
`ifdef SEG_SCAN_BRIGHT_EN
            p_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            fd_q     <= fd_d;
            shadow_q <= shadow_d;
`ifdef SEG_SCAN_BRIGHT_EN
            p_q      <= p_d;
`endif
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_done = fd_q;

endmodule
